alien_hit_detector: RTL and testbench

ALIEN_HIT_DETECTOR -- requirements
Module: alien_hit_detector

---
 rtl/galaxian_pkg.sv | 34 +++
 rtl/aabb_overlap.sv | 27 ++
 rtl/alien_hit_detector.sv | 153 +++++++++++++++
 tb/tb_alien_hit_detector.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galaxian_pkg.sv
// Shared constants, state encoding and helpers for the alien hit detector.
package galaxian_pkg;

  localparam int unsigned NUM_ALIENS = 12;
  localparam int unsigned ALIEN_W    = 16;
  localparam int unsigned ALIEN_H    = 16;
  localparam int unsigned MISSILE_W  = 2;
  localparam int unsigned MISSILE_H  = 8;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } det_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  // Number of set bits in a flag vector.
  function automatic logic [CNT_W-1:0] count_flags(input logic [NUM_ALIENS-1:0] f);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_ALIENS; i++) begin
      s = s + CNT_W'(f[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational missile/alien bounding-box overlap test, widened by one bit
// so that coordinates near the screen edge never wrap.
module aabb_overlap
  import galaxian_pkg::*;
(
  input  logic [COORD_W-1:0] mx,
  input  logic [COORD_W-1:0] my,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  output logic               overlap_c
);

  localparam int unsigned WW = COORD_W + 1;

  logic [WW-1:0] mx_w, my_w, ax_w, ay_w;

  assign mx_w = WW'(mx);
  assign my_w = WW'(my);
  assign ax_w = WW'(ax);
  assign ay_w = WW'(ay);

  assign overlap_c = (mx_w + WW'(MISSILE_W) > ax_w) &&
                     (mx_w < ax_w + WW'(ALIEN_W))   &&
                     (my_w + WW'(MISSILE_H) > ay_w) &&
                     (my_w < ay_w + WW'(ALIEN_H));

endmodule

// File: rtl/alien_hit_detector.sv
// Per-frame scan of the alien position table against the player missile;
// destroys at most one (lowest-index) alien per scan and keeps sticky flags.
module alien_hit_detector
  import galaxian_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               missile_active,
  input  logic [COORD_W-1:0] missile_x,
  input  logic [COORD_W-1:0] missile_y,
  output logic [IDX_W-1:0]   alien_idx,
  input  logic [COORD_W-1:0] alien_x_in,
  input  logic [COORD_W-1:0] alien_y_in,
  output logic               alien1_hit,
  output logic               alien2_hit,
  output logic               alien3_hit,
  output logic               alien4_hit,
  output logic               alien5_hit,
  output logic               alien6_hit,
  output logic               alien7_hit,
  output logic               alien8_hit,
  output logic               alien9_hit,
  output logic               alien10_hit,
  output logic               alien11_hit,
  output logic               alien12_hit,
  output logic               missile_clear,
  output logic [CNT_W-1:0]   hit_count,
  output logic               all_dead
);

  det_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      alien_idx_q, alien_idx_d;
  pos_t                  mis_q, mis_d;
  logic                  win_valid_q, win_valid_d;
  logic [IDX_W-1:0]      win_idx_q, win_idx_d;
  logic [NUM_ALIENS-1:0] flags_q, flags_d;
  logic                  missile_clear_q, missile_clear_d;
  logic [CNT_W-1:0]      hit_count_q, hit_count_d;
  logic                  all_dead_q, all_dead_d;

  logic                  overlap_c;
  logic [IDX_W-1:0]      cmp_idx_c;
  logic                  candidate_c;

  aabb_overlap u_overlap (
    .mx        (mis_q.x),
    .my        (mis_q.y),
    .ax        (alien_x_in),
    .ay        (alien_y_in),
    .overlap_c (overlap_c)
  );

  // Table data lags the address by a cycle, so cnt_q-1 is the index under test.
  assign cmp_idx_c   = IDX_W'(cnt_q - CNT_W'(1));
  assign candidate_c = (state_q == ST_SCAN) && (cnt_q != '0) && overlap_c &&
                       !flags_q[cmp_idx_c];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    alien_idx_d     = '0;
    mis_d           = mis_q;
    win_valid_d     = win_valid_q;
    win_idx_d       = win_idx_q;
    flags_d         = flags_q;
    missile_clear_d = 1'b0;
    hit_count_d     = count_flags(flags_q);
    all_dead_d      = &flags_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && missile_active) begin
          state_d     = ST_SCAN;
          cnt_d       = '0;
          mis_d.x     = missile_x;
          mis_d.y     = missile_y;
          win_valid_d = 1'b0;
          win_idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q < CNT_W'(NUM_ALIENS - 1)) begin
          alien_idx_d = IDX_W'(cnt_q + CNT_W'(1));
        end
        // First overlap found wins; later ones are ignored.
        if (candidate_c && !win_valid_q) begin
          win_valid_d = 1'b1;
          win_idx_d   = cmp_idx_c;
        end
        if (cnt_q == CNT_W'(NUM_ALIENS)) begin
          state_d = ST_DONE;
          if (win_valid_d) begin
            flags_d[win_idx_d] = 1'b1;
            missile_clear_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        win_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      alien_idx_q     <= '0;
      mis_q           <= '0;
      win_valid_q     <= 1'b0;
      win_idx_q       <= '0;
      flags_q         <= '0;
      missile_clear_q <= 1'b0;
      hit_count_q     <= '0;
      all_dead_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      alien_idx_q     <= alien_idx_d;
      mis_q           <= mis_d;
      win_valid_q     <= win_valid_d;
      win_idx_q       <= win_idx_d;
      flags_q         <= flags_d;
      missile_clear_q <= missile_clear_d;
      hit_count_q     <= hit_count_d;
      all_dead_q      <= all_dead_d;
    end
  end

  assign alien_idx     = alien_idx_q;
  assign missile_clear = missile_clear_q;
  assign hit_count     = hit_count_q;
  assign all_dead      = all_dead_q;
  assign alien1_hit    = flags_q[0];
  assign alien2_hit    = flags_q[1];
  assign alien3_hit    = flags_q[2];
  assign alien4_hit    = flags_q[3];
  assign alien5_hit    = flags_q[4];
  assign alien6_hit    = flags_q[5];
  assign alien7_hit    = flags_q[6];
  assign alien8_hit    = flags_q[7];
  assign alien9_hit    = flags_q[8];
  assign alien10_hit   = flags_q[9];
  assign alien11_hit   = flags_q[10];
  assign alien12_hit   = flags_q[11];

endmodule

// File: tb/tb_alien_hit_detector.sv
// Self-checking bench for alien_hit_detector: directed scenarios plus random
// scans compared against a table-driven reference model.
module tb_alien_hit_detector;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       missile_active = 1'b0;
  logic [9:0] missile_x = '0;
  logic [9:0] missile_y = '0;
  logic [3:0] alien_idx;
  logic [9:0] alien_x_in = '0;
  logic [9:0] alien_y_in = '0;
  logic       alien1_hit, alien2_hit, alien3_hit, alien4_hit, alien5_hit, alien6_hit;
  logic       alien7_hit, alien8_hit, alien9_hit, alien10_hit, alien11_hit, alien12_hit;
  logic       missile_clear;
  logic [3:0] hit_count;
  logic       all_dead;

  logic [11:0] flags_obs;
  logic [9:0]  ax_tab [12];
  logic [9:0]  ay_tab [12];
  bit   [11:0] m_flags;
  int          checks = 0;
  int          failures = 0;

  always #5 Clk = ~Clk;

  alien_hit_detector dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .missile_active (missile_active),
    .missile_x      (missile_x),
    .missile_y      (missile_y),
    .alien_idx      (alien_idx),
    .alien_x_in     (alien_x_in),
    .alien_y_in     (alien_y_in),
    .alien1_hit     (alien1_hit),
    .alien2_hit     (alien2_hit),
    .alien3_hit     (alien3_hit),
    .alien4_hit     (alien4_hit),
    .alien5_hit     (alien5_hit),
    .alien6_hit     (alien6_hit),
    .alien7_hit     (alien7_hit),
    .alien8_hit     (alien8_hit),
    .alien9_hit     (alien9_hit),
    .alien10_hit    (alien10_hit),
    .alien11_hit    (alien11_hit),
    .alien12_hit    (alien12_hit),
    .missile_clear  (missile_clear),
    .hit_count      (hit_count),
    .all_dead       (all_dead)
  );

  assign flags_obs = {alien12_hit, alien11_hit, alien10_hit, alien9_hit, alien8_hit, alien7_hit,
                      alien6_hit, alien5_hit, alien4_hit, alien3_hit, alien2_hit, alien1_hit};

  // Position table: read data appears one cycle after the address.
  always @(posedge Clk) begin
    if (alien_idx < 4'd12) begin
      alien_x_in <= ax_tab[alien_idx];
      alien_y_in <= ay_tab[alien_idx];
    end else begin
      alien_x_in <= '0;
      alien_y_in <= '0;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit ovl(int mx, int my, int ax, int ay);
    return (mx + 2 > ax) && (mx < ax + 16) && (my + 8 > ay) && (my < ay + 16);
  endfunction

  function automatic int predict(int mx, int my);
    for (int k = 0; k < 12; k++) begin
      if (!m_flags[k] && ovl(mx, my, int'(ax_tab[k]), int'(ay_tab[k]))) return k;
    end
    return -1;
  endfunction

  function automatic int popc(bit [11:0] f);
    int s = 0;
    for (int k = 0; k < 12; k++) s += int'(f[k]);
    return s;
  endfunction

  task automatic set_all_off();
    for (int k = 0; k < 12; k++) begin
      ax_tab[k] = 10'd1000;
      ay_tab[k] = 10'd1000;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    frame_tick = 1'b0;
    missile_active = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    m_flags = '0;
  endtask

  // One full scan: frame_tick in cycle T, checks at T+1..T+15.
  task automatic run_scan(input int mx, input int my, input string name, input bit scramble);
    int exp_w;
    exp_w = predict(mx, my);
    missile_x = 10'(mx);
    missile_y = 10'(my);
    missile_active = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    if (scramble) begin
      missile_x = 10'($urandom);
      missile_y = 10'($urandom);
      missile_active = 1'($urandom);
    end
    for (int n = 1; n <= 13; n++) begin
      checks++;
      if (n <= 12 && alien_idx !== 4'(n - 1)) begin
        failures++;
        $display("FAIL %s idx@T+%0d: got %0d expected %0d", name, n, alien_idx, n - 1);
      end
      checks++;
      if (missile_clear !== 1'b0) begin
        failures++;
        $display("FAIL %s early_clear@T+%0d: got %b expected 0", name, n, missile_clear);
      end
      tick();
    end
    if (exp_w >= 0) m_flags[exp_w] = 1'b1;
    checks++;
    if (flags_obs !== m_flags) begin
      failures++;
      $display("FAIL %s flags@T+14: got %03h expected %03h", name, flags_obs, m_flags);
    end
    checks++;
    if (missile_clear !== (exp_w >= 0)) begin
      failures++;
      $display("FAIL %s clear@T+14: got %b expected %b", name, missile_clear, exp_w >= 0);
    end
    tick();
    checks++;
    if (missile_clear !== 1'b0) begin
      failures++;
      $display("FAIL %s clear@T+15: got %b expected 0", name, missile_clear);
    end
    checks++;
    if (hit_count !== 4'(popc(m_flags)) || all_dead !== (m_flags == 12'hfff)) begin
      failures++;
      $display("FAIL %s count@T+15: got %0d/%b expected %0d/%b", name, hit_count, all_dead,
               popc(m_flags), m_flags == 12'hfff);
    end
    missile_active = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #2;
    checks++;
    if (flags_obs !== 12'h000 || missile_clear !== 1'b0 || hit_count !== 4'd0 ||
        all_dead !== 1'b0 || alien_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got flags=%03h clr=%b cnt=%0d dead=%b idx=%0d expected all 0",
               flags_obs, missile_clear, hit_count, all_dead, alien_idx);
    end
    do_reset();
  endtask

  task automatic test_single_hit();
    do_reset();
    set_all_off();
    ax_tab[2] = 10'd95;
    ay_tab[2] = 10'd190;
    run_scan(100, 200, "single_hit", 1'b0);
    checks++;
    if (alien3_hit !== 1'b1 || hit_count !== 4'd1) begin
      failures++;
      $display("FAIL single_hit_alien3: got hit=%b cnt=%0d expected 1/1", alien3_hit, hit_count);
    end
  endtask

  task automatic test_lowest_index();
    do_reset();
    set_all_off();
    ax_tab[4] = 10'd100; ay_tab[4] = 10'd200;
    ax_tab[8] = 10'd100; ay_tab[8] = 10'd200;
    run_scan(104, 204, "lowest_first", 1'b0);
    checks++;
    if (flags_obs !== 12'h010) begin
      failures++;
      $display("FAIL lowest_first_flags: got %03h expected 010", flags_obs);
    end
    run_scan(104, 204, "lowest_second", 1'b0);
    checks++;
    if (flags_obs !== 12'h110) begin
      failures++;
      $display("FAIL lowest_second_flags: got %03h expected 110", flags_obs);
    end
  endtask

  task automatic test_edge();
    do_reset();
    set_all_off();
    ax_tab[0] = 10'd100; ay_tab[0] = 10'd200;
    run_scan(116, 200, "edge_116", 1'b0);
    run_scan(115, 200, "edge_115", 1'b0);
    checks++;
    if (alien1_hit !== 1'b1) begin
      failures++;
      $display("FAIL edge_115_flag: got %b expected 1", alien1_hit);
    end
    // Far corner: mx+2 exceeds 10 bits and must not wrap.
    ax_tab[1] = 10'd1010; ay_tab[1] = 10'd1010;
    run_scan(1023, 1020, "edge_corner", 1'b0);
  endtask

  task automatic test_ignored_ticks();
    int bad;
    int clears;
    do_reset();
    set_all_off();
    ax_tab[0] = 10'd100; ay_tab[0] = 10'd200;
    ax_tab[1] = 10'd100; ay_tab[1] = 10'd200;
    missile_x = 10'd100; missile_y = 10'd200;
    missile_active = 1'b0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (alien_idx !== 4'd0 || missile_clear !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || flags_obs !== 12'h000) begin
      failures++;
      $display("FAIL inactive_tick: got %0d active cycles flags=%03h expected 0/000", bad, flags_obs);
    end
    missile_active = 1'b1;
    frame_tick = 1'b1;
    tick();
    clears = 0;
    for (int c = 1; c <= 40; c++) begin
      if (missile_clear === 1'b1) clears++;
      frame_tick = (c == 5 || c == 14);
      tick();
    end
    frame_tick = 1'b0;
    missile_active = 1'b0;
    m_flags[0] = 1'b1;
    checks++;
    if (clears != 1) begin
      failures++;
      $display("FAIL busy_tick_clears: got %0d expected 1", clears);
    end
    checks++;
    if (flags_obs !== m_flags || hit_count !== 4'd1) begin
      failures++;
      $display("FAIL busy_tick_flags: got %03h/%0d expected %03h/1", flags_obs, hit_count, m_flags);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    set_all_off();
    ax_tab[0] = 10'd100; ay_tab[0] = 10'd200;
    missile_x = 10'd100; missile_y = 10'd200;
    missile_active = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (flags_obs !== 12'h000 || missile_clear !== 1'b0 || alien_idx !== 4'd0 || hit_count !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_state: got flags=%03h clr=%b idx=%0d cnt=%0d expected 0",
               flags_obs, missile_clear, alien_idx, hit_count);
    end
    tick();
    tick();
    Reset = 1'b1;
    m_flags = '0;
    run_scan(100, 200, "after_reset", 1'b0);
    checks++;
    if (alien1_hit !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_hit: got %b expected 1", alien1_hit);
    end
  endtask

  task automatic test_all_dead();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      ax_tab[k] = 10'd100;
      ay_tab[k] = 10'd200;
    end
    for (int s = 0; s < 12; s++) run_scan(100, 200, "kill_all", 1'b0);
    checks++;
    if (hit_count !== 4'd12 || all_dead !== 1'b1) begin
      failures++;
      $display("FAIL all_dead: got %0d/%b expected 12/1", hit_count, all_dead);
    end
    run_scan(100, 200, "thirteenth", 1'b0);
    checks++;
    if (hit_count !== 4'd12 || flags_obs !== 12'hfff) begin
      failures++;
      $display("FAIL thirteenth_state: got %0d/%03h expected 12/fff", hit_count, flags_obs);
    end
  endtask

  task automatic test_random();
    int mx, my, v;
    do_reset();
    for (int s = 0; s < 24; s++) begin
      mx = int'($urandom_range(20, 1003));
      my = int'($urandom_range(20, 1003));
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          ax_tab[k] = 10'd1000;
          ay_tab[k] = 10'd1000;
        end else begin
          v = mx + int'($urandom_range(0, 40)) - 20;
          v = (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
          ax_tab[k] = 10'(v);
          v = my + int'($urandom_range(0, 40)) - 20;
          v = (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
          ay_tab[k] = 10'(v);
        end
      end
      run_scan(mx, my, "random", 1'b1);
    end
  endtask

  initial begin
    set_all_off();
    m_flags = '0;
    test_reset();
    test_single_hit();
    test_lowest_index();
    test_edge();
    test_ignored_ticks();
    test_reset_mid_scan();
    test_all_dead();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
